wb_scoreboard: RTL and testbench

Writeback arbiter and register scoreboard for the integer pipeline. Merges results from the load unit and the multiply/divide unit into the single integer register file write port. Tracks destination registers of in-flight long-latency instructions and stalls issue on RAW/WAW hazards against them. Sits between the execute-side result producers and the integer register file, beside the decode/issue stage.

---
 rtl/wb_scoreboard.sv | 113 +++++++++++
 tb/tb_wb_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// Writeback arbiter and register scoreboard: merges load and mul/div results onto
// the single register-file write port and stalls issue on hazards against in-flight writes.
module wb_scoreboard #(
    parameter int unsigned NPEND = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_v,
    input  logic [4:0]  id_rs1,
    input  logic        id_rs1_use,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs2_use,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_v,
    input  logic        id_long,
    output logic        id_stall,
    input  logic        ld_v,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        md_v,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        wb_v,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [5:0]  pend_cnt,
    output logic        sb_err
);
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;

    logic [31:1]   r_pending;
    logic [CW-1:0] r_pend_cnt;
    logic          r_wb_v;
    logic [RW-1:0] r_wb_rd;
    logic [DW-1:0] r_wb_data;
    logic          r_sb_err;

    logic [31:0]   w_pend;
    logic          w_hit;
    logic          w_full;
    logic          w_fire;
    logic          w_set;
    logic          w_acc;
    logic [RW-1:0] w_res_rd;
    logic [DW-1:0] w_res_data;
    logic          w_clr;
    logic          w_clr_hit;
    logic [31:1]   w_pend_nxt;
    logic [CW-1:0] w_cnt_nxt;

    // x0 is never pending, so index the full 32-entry view directly
    assign w_pend = {r_pending, 1'b0};

    assign w_hit  = (id_rs1_use & w_pend[id_rs1]) |
                    (id_rs2_use & w_pend[id_rs2]) |
                    (id_rd_v    & w_pend[id_rd]);
    assign w_full = (r_pend_cnt == CW'(NPEND)) & id_long & id_rd_v & (id_rd != '0);

    assign id_stall = id_v & (w_hit | w_full);
    assign w_fire   = id_v & ~id_stall;
    assign w_set    = w_fire & id_long & id_rd_v & (id_rd != '0);

    // Loads cannot be back-pressured, so they always win the write port
    assign md_ready   = ~ld_v;
    assign w_acc      = ld_v | md_v;
    assign w_res_rd   = ld_v ? ld_rd   : md_rd;
    assign w_res_data = ld_v ? ld_data : md_data;
    assign w_clr      = w_acc & (w_res_rd != '0);
    assign w_clr_hit  = w_clr & w_pend[w_res_rd];

    always_comb begin
        w_pend_nxt = r_pending;
        for (int i = 1; i < 32; i++) begin
            if (w_clr && (w_res_rd == RW'(i)))
                w_pend_nxt[i] = 1'b0;
            if (w_set && (id_rd == RW'(i)))
                w_pend_nxt[i] = 1'b1;
        end
    end

    // Count only clears that actually retire a pending bit so pend_cnt tracks the mask
    assign w_cnt_nxt = r_pend_cnt + CW'(w_set) - CW'(w_clr_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_pend_cnt <= '0;
            r_wb_v     <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_sb_err   <= 1'b0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
            r_wb_v     <= w_clr;
            if (w_clr) begin
                r_wb_rd   <= w_res_rd;
                r_wb_data <= w_res_data;
            end
            if (w_clr && !w_pend[w_res_rd])
                r_sb_err <= 1'b1;
        end
    end

    assign wb_v     = r_wb_v;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign pend_cnt = r_pend_cnt;
    assign sb_err   = r_sb_err;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: expected writebacks are queued when results
// are presented and popped by a monitor whenever the register-file write fires.
module tb_wb_scoreboard;
    logic        clk;
    logic        rst_n;
    logic        id_v;
    logic [4:0]  id_rs1;
    logic        id_rs1_use;
    logic [4:0]  id_rs2;
    logic        id_rs2_use;
    logic [4:0]  id_rd;
    logic        id_rd_v;
    logic        id_long;
    logic        id_stall;
    logic        ld_v;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        md_v;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [5:0]  pend_cnt;
    logic        sb_err;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    wb_scoreboard #(.NPEND(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_v(id_v), .id_rs1(id_rs1), .id_rs1_use(id_rs1_use),
        .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
        .id_rd(id_rd), .id_rd_v(id_rd_v), .id_long(id_long), .id_stall(id_stall),
        .ld_v(ld_v), .ld_rd(ld_rd), .ld_data(ld_data),
        .md_v(md_v), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .wb_v(wb_v), .wb_rd(wb_rd), .wb_data(wb_data),
        .pend_cnt(pend_cnt), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_v = 0; id_rs1 = 0; id_rs1_use = 0; id_rs2 = 0; id_rs2_use = 0;
        id_rd = 0; id_rd_v = 0; id_long = 0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        id_clear();
        id_v = 1; id_rd = rd; id_rd_v = 1; id_long = 1;
    endtask

    task automatic drive_ld(input logic [4:0] rd, input logic [31:0] data);
        ld_v = 1; ld_rd = rd; ld_data = data;
        if (rd != 0) exp_q.push_back('{rd: rd, data: data});
    endtask

    // Every write port pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && wb_v) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 32'(wb_rd), 32'hFFFF_FFFF);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        rst_n = 0;
        id_clear();
        ld_v = 0; ld_rd = 0; ld_data = 0;
        md_v = 0; md_rd = 0; md_data = 0;
        step();
        chk("rst_pend_cnt", 32'(pend_cnt), 0);
        chk("rst_wb_v", 32'(wb_v), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_sb_err", 32'(sb_err), 0);
        rst_n = 1;
        step();

        // RAW stall on x5 until the load returns
        issue_long(5);
        #1 chk("long5_nostall", 32'(id_stall), 0);
        step();
        id_clear();
        id_v = 1; id_rs1 = 5; id_rs1_use = 1; id_rd = 6; id_rd_v = 1;
        #1 chk("raw5_stall", 32'(id_stall), 1);
        chk("raw5_cnt", 32'(pend_cnt), 1);
        step();
        chk("raw5_stall_hold", 32'(id_stall), 1);
        drive_ld(5, 32'h1234);
        #1 chk("raw5_stall_same_wb", 32'(id_stall), 1);
        step();
        ld_v = 0;
        #1 chk("raw5_stall_drop", 32'(id_stall), 0);
        chk("raw5_wb_v", 32'(wb_v), 1);
        chk("raw5_cnt0", 32'(pend_cnt), 0);
        step();
        id_clear();

        // Load beats mul/div in the same cycle
        issue_long(3); step();
        issue_long(4); step();
        id_clear();
        drive_ld(3, 32'hAAAA_0003);
        md_v = 1; md_rd = 4; md_data = 32'hBBBB_0004;
        #1 chk("arb_md_ready0", 32'(md_ready), 0);
        chk("arb_cnt2", 32'(pend_cnt), 2);
        step();
        ld_v = 0;
        #1 chk("arb_md_ready1", 32'(md_ready), 1);
        chk("arb_wb_rd3", 32'(wb_rd), 3);
        chk("arb_cnt1", 32'(pend_cnt), 1);
        exp_q.push_back('{rd: 5'd4, data: 32'hBBBB_0004});
        step();
        md_v = 0;
        chk("arb_wb_rd4", 32'(wb_rd), 4);
        chk("arb_cnt0", 32'(pend_cnt), 0);
        step();

        // Capacity limit at NPEND outstanding long writes
        for (int r = 1; r <= 4; r++) begin
            issue_long(5'(r));
            step();
        end
        issue_long(6);
        #1 chk("cap_stall", 32'(id_stall), 1);
        chk("cap_cnt4", 32'(pend_cnt), 4);
        id_long = 0; id_rd = 7;
        #1 chk("cap_short_nostall", 32'(id_stall), 0);
        id_long = 1; id_rd = 6;
        drive_ld(1, 32'h0000_0011);
        #1 chk("cap_stall_same_wb", 32'(id_stall), 1);
        step();
        ld_v = 0;
        #1 chk("cap_free", 32'(id_stall), 0);
        chk("cap_cnt3", 32'(pend_cnt), 3);
        step();
        id_clear();
        chk("cap_cnt4b", 32'(pend_cnt), 4);
        for (int k = 0; k < 4; k++) begin
            logic [4:0] rds [4] = '{5'd2, 5'd3, 5'd4, 5'd6};
            drive_ld(rds[k], 32'hC0DE_0000 + 32'(k));
            step();
        end
        ld_v = 0;
        step();
        chk("cap_drain_cnt", 32'(pend_cnt), 0);

        // x0 never tracked, never written back
        issue_long(0);
        #1 chk("x0_nostall", 32'(id_stall), 0);
        step();
        id_clear();
        chk("x0_cnt", 32'(pend_cnt), 0);
        drive_ld(0, 32'hDEAD_0000);
        step();
        ld_v = 0;
        chk("x0_wb_v", 32'(wb_v), 0);
        chk("x0_sb_err", 32'(sb_err), 0);

        // Writeback to a register that was never pending
        drive_ld(9, 32'h0000_0909);
        step();
        ld_v = 0;
        chk("err_wb_v", 32'(wb_v), 1);
        chk("err_sb_err", 32'(sb_err), 1);
        chk("err_cnt", 32'(pend_cnt), 0);
        step(); step();
        chk("err_sticky", 32'(sb_err), 1);

        // WAW stall on x8
        issue_long(8); step();
        id_clear();
        id_v = 1; id_rd = 8; id_rd_v = 1;
        #1 chk("waw_stall", 32'(id_stall), 1);
        id_clear();
        drive_ld(8, 32'h8888_8888);
        step();
        ld_v = 0;
        step();
        chk("waw_cnt0", 32'(pend_cnt), 0);

        // Async reset with writes in flight
        for (int r = 10; r <= 13; r++) begin
            issue_long(5'(r));
            step();
        end
        id_clear();
        drive_ld(13, 32'h1313_1313);
        step();
        ld_v = 0;
        chk("pre_rst_cnt", 32'(pend_cnt), 3);
        chk("pre_rst_wb_v", 32'(wb_v), 1);
        #5;
        rst_n = 0;
        id_v = 1; id_rs1 = 10; id_rs1_use = 1; id_rs2 = 11; id_rs2_use = 1; id_rd = 12; id_rd_v = 1;
        #1;
        chk("rst_mid_cnt", 32'(pend_cnt), 0);
        chk("rst_mid_wb_v", 32'(wb_v), 0);
        chk("rst_mid_stall", 32'(id_stall), 0);
        chk("rst_mid_sb_err", 32'(sb_err), 0);
        id_clear();
        step();
        rst_n = 1;
        step();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
